// File: rtl/data_cache.sv
// data_cache: direct-mapped, write-through, no-write-allocate data cache (one 32-bit word per line).
// Latency: load hit 0 cycles (combinational); load miss 1 stall cycle, data presented in FILL; stores 0 cycles.
// Backpressure: stall_o high for the single miss cycle; requester holds req_i/WE_i/A_i/WD_i stable meanwhile.
//
// Ports:
//   clk, rst_n            clock (rising edge), asynchronous active-low reset
//   req_i, WE_i, A_i, WD_i  memory-stage access (WE_i: 00 load, 01 word, 10 half, 11 byte store)
//   RD_o, stall_o         load data and stall back to the memory stage
//   mem_WE_o/A_o/WD_o     request to data_mem; mem_RD_i is its combinational read data
//   hit_cnt_o, miss_cnt_o statistics; live only when DCACHE_STATS_EN is defined, otherwise tied to 0
module data_cache #(
    parameter int SETS       = 8,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_i,
    input  logic [1:0]            WE_i,
    input  logic [DATA_WIDTH-1:0] A_i,
    input  logic [DATA_WIDTH-1:0] WD_i,
    output logic [DATA_WIDTH-1:0] RD_o,
    output logic                  stall_o,
    output logic [1:0]            mem_WE_o,
    output logic [DATA_WIDTH-1:0] mem_A_o,
    output logic [DATA_WIDTH-1:0] mem_WD_o,
    input  logic [DATA_WIDTH-1:0] mem_RD_i,
    output logic [31:0]           hit_cnt_o,
    output logic [31:0]           miss_cnt_o
);
    localparam int IDX  = $clog2(SETS);
    localparam int TAGW = DATA_WIDTH - 2 - IDX;

    typedef enum logic {IDLE, FILL} state_t;

    state_t                state_q, state_d;
    logic [DATA_WIDTH-1:0] fill_addr_q;
    logic [SETS-1:0]       valid_q;
    logic [TAGW-1:0]       tag_q  [SETS];
    logic [DATA_WIDTH-1:0] line_q [SETS];

    // Address decode for the requested word and for the word after it
    // (the second word touched by a store that crosses a word boundary).
    logic [IDX-1:0]        idx, idx_nxt, fill_idx;
    logic [TAGW-1:0]       tag, tag_nxt, fill_tag;
    logic [DATA_WIDTH-3:0] word_nxt;

    assign idx      = A_i[IDX+1:2];
    assign tag      = A_i[DATA_WIDTH-1:IDX+2];
    assign word_nxt = A_i[DATA_WIDTH-1:2] + {{(DATA_WIDTH-3){1'b0}}, 1'b1};
    assign idx_nxt  = word_nxt[IDX-1:0];
    assign tag_nxt  = word_nxt[DATA_WIDTH-3:IDX];
    assign fill_idx = fill_addr_q[IDX+1:2];
    assign fill_tag = fill_addr_q[DATA_WIDTH-1:IDX+2];

    logic is_idle, line_hit, next_hit, load_hit, load_miss, store;
    logic [1:0]            off;
    logic                  in_word;
    logic [3:0]            byte_mask;
    logic [DATA_WIDTH-1:0] wd_sh;

    assign is_idle   = (state_q == IDLE);
    assign off       = A_i[1:0];
    assign line_hit  = valid_q[idx] && (tag_q[idx] == tag);
    assign next_hit  = valid_q[idx_nxt] && (tag_q[idx_nxt] == tag_nxt);
    assign load_hit  = is_idle && req_i && (WE_i == 2'b00) && (off == 2'b00) && line_hit;
    assign load_miss = is_idle && req_i && (WE_i == 2'b00) && (off == 2'b00) && !line_hit;
    assign store     = is_idle && req_i && (WE_i != 2'b00);
    assign wd_sh     = WD_i << {off, 3'b000};

    // Store width decode: which bytes of the line are written, and whether the
    // store stays inside one word (otherwise both touched lines are dropped).
    always_comb begin
        in_word   = 1'b0;
        byte_mask = 4'b0000;
        case (WE_i)
            2'b01: begin
                in_word   = (off == 2'b00);
                byte_mask = 4'b1111;
            end
            2'b10: begin
                in_word   = (off != 2'b11);
                byte_mask = 4'b0011 << off;
            end
            2'b11: begin
                in_word   = 1'b1;
                byte_mask = 4'b0001 << off;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            fill_addr_q <= '0;
        end else begin
            state_q <= state_d;
            if (load_miss) fill_addr_q <= {A_i[DATA_WIDTH-1:2], 2'b00};
        end
    end

    always_comb begin
        state_d  = state_q;
        stall_o  = 1'b0;
        RD_o     = mem_RD_i;
        mem_WE_o = 2'b00;
        mem_A_o  = A_i;
        mem_WD_o = WD_i;
        case (state_q)
            IDLE: begin
                if (load_miss) state_d = FILL;
                stall_o = load_miss;
                if (load_hit) RD_o = line_q[idx];
                if (store) mem_WE_o = WE_i;
            end
            FILL: begin
                state_d = IDLE;
                mem_A_o = fill_addr_q;
            end
            default: state_d = IDLE;
        endcase
        // Quiet outputs while reset is held, whatever the request inputs do.
        if (!rst_n) begin
            stall_o  = 1'b0;
            RD_o     = '0;
            mem_WE_o = 2'b00;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
        end else if (state_q == FILL) begin
            valid_q[fill_idx] <= 1'b1;
        end else if (store && !in_word) begin
            if (line_hit) valid_q[idx]     <= 1'b0;
            if (next_hit) valid_q[idx_nxt] <= 1'b0;
        end
    end

    // Line payload needs no reset: valid_q gates every use of it, and state_q
    // leaves FILL asynchronously so an interrupted fill never writes.
    always_ff @(posedge clk) begin
        if (state_q == FILL) begin
            line_q[fill_idx] <= mem_RD_i;
            tag_q[fill_idx]  <= fill_tag;
        end else if (store && in_word && line_hit) begin
            for (int b = 0; b < 4; b++) begin
                if (byte_mask[b]) line_q[idx][8*b +: 8] <= wd_sh[8*b +: 8];
            end
        end
    end

`ifdef DCACHE_STATS_EN
    logic [31:0] hit_q, miss_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hit_q  <= '0;
            miss_q <= '0;
        end else begin
            if (load_hit && (hit_q != 32'hFFFF_FFFF))   hit_q  <= hit_q + 32'd1;
            if (load_miss && (miss_q != 32'hFFFF_FFFF)) miss_q <= miss_q + 32'd1;
        end
    end

    assign hit_cnt_o  = hit_q;
    assign miss_cnt_o = miss_q;
`else
    assign hit_cnt_o  = '0;
    assign miss_cnt_o = '0;
`endif

endmodule
